// File: rtl/alu_digit_serial_if.sv
// alu_digit_serial_if: operand/result handshake bundle for the digit-serial ALU.
interface alu_digit_serial_if #(parameter int WIDTH = 32);
    logic             InValid;
    logic             InReady;
    logic [WIDTH-1:0] InA;
    logic [WIDTH-1:0] InB;
    logic [2:0]       Op;
    logic             Flush;
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] Result;
    logic             FlagN;
    logic             FlagZ;
    logic             FlagC;
    logic             FlagV;
    modport master (output InValid, InA, InB, Op, Flush, OutReady,
                    input  InReady, OutValid, Result, FlagN, FlagZ, FlagC, FlagV);
    modport slave  (input  InValid, InA, InB, Op, Flush, OutReady,
                    output InReady, OutValid, Result, FlagN, FlagZ, FlagC, FlagV);
endinterface

// File: rtl/alu_digit_serial.sv
// alu_digit_serial: WIDTH-bit ADD/SUB/logic unit processing DIGIT bits per cycle with NZCV flags.
module alu_digit_serial #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input logic              Clk,
    input logic              ResetN,
    alu_digit_serial_if.slave bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW = NDIG > 1 ? $clog2(NDIG) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} stateE;
    stateE            state;
    logic [WIDTH-1:0] shA, shB, result;
    logic [2:0]       op;
    logic             carry, inReady, outValid, flagN, flagZ, flagC, flagV;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] a, b, logicDig, digOut;
    logic [DIGIT:0]   sum;
    logic [WIDTH+DIGIT-1:0] cat;
    logic [WIDTH-1:0] nextResult;
    logic             isArith, last, vDig, accept;
    assign a = shA[DIGIT-1:0];
    assign b = shB[DIGIT-1:0];
    assign sum = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, carry};
    assign logicDig = (op[2:1] == 2'b01 ? a & b : op[2:1] == 2'b10 ? a | b : a ^ b) ^ {DIGIT{op[0]}};
    assign isArith = op[2:1] == 2'b00;
    assign digOut = isArith ? sum[DIGIT-1:0] : logicDig;
    // New digit enters at the MSB end so after NDIG digits the word is in place.
    assign cat = {digOut, result};
    assign nextResult = cat[WIDTH+DIGIT-1:DIGIT];
    // b already carries the SUB inversion, so this is carry-in XOR carry-out of the MSB.
    assign vDig = (a[DIGIT-1] ~^ b[DIGIT-1]) & (sum[DIGIT-1] ^ a[DIGIT-1]);
    assign last = cnt == CW'(NDIG - 1);
    assign accept = bus.InValid & inReady & ~bus.Flush;
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state    <= IDLE;
            shA      <= '0;
            shB      <= '0;
            result   <= '0;
            op       <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            inReady  <= 1'b0;
            outValid <= 1'b0;
            flagN    <= 1'b0;
            flagZ    <= 1'b0;
            flagC    <= 1'b0;
            flagV    <= 1'b0;
        end else if (bus.Flush) begin
            state    <= IDLE;
            inReady  <= 1'b1;
            outValid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    inReady <= ~accept;
                    if (accept) begin
                        shA   <= bus.InA;
                        shB   <= bus.Op == 3'b001 ? ~bus.InB : bus.InB;
                        op    <= bus.Op;
                        carry <= bus.Op == 3'b001;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    shA    <= shA >> DIGIT;
                    shB    <= shB >> DIGIT;
                    result <= nextResult;
                    carry  <= sum[DIGIT];
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        state    <= DONE;
                        outValid <= 1'b1;
                        flagN    <= nextResult[WIDTH-1];
                        flagZ    <= nextResult == '0;
                        flagC    <= isArith & sum[DIGIT];
                        flagV    <= isArith & vDig;
                    end
                end
                DONE: begin
                    if (bus.OutReady) begin
                        state    <= IDLE;
                        outValid <= 1'b0;
                        inReady  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.InReady  = inReady;
    assign bus.OutValid = outValid;
    assign bus.Result   = result;
    assign bus.FlagN    = flagN;
    assign bus.FlagZ    = flagZ;
    assign bus.FlagC    = flagC;
    assign bus.FlagV    = flagV;
endmodule
